buffer_access_arbiter: RTL
==========================

Name: buffer_access_arbiter

Overview:
- Sits between the 64-byte single-port endpoint data buffer SRAM and its two agents:
  - the USB side (RX packet store / TX packet fetch), sequenced by protocol_controller via D_Mode and clear;
  - the AHB-Lite slave side (firmware store / fetch).
- Grants one byte access per cycle, maintains FIFO pointers and Buffer_Occupancy, and handles clear/flush.
- Drives the Buffer_Occupancy consumed by protocol_controller.

Parameters:
- DEPTH, 64, buffer depth in bytes (power of two)
- ADDR_W, 6, log2(DEPTH)
- MAX_STALL, 4, cycles an AHB request may be refused before it takes priority (starve guard)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- D_Mode  in  1  from protocol_controller; 1 = host-to-endpoint (USB writes), 0 = endpoint-to-host (USB reads)
- clear  in  1  from protocol_controller; empty the buffer
- flush  in  1  from AHB slave; empty the buffer
- usb_wr_req  in  1  USB RX byte store request
- usb_wdata  in  8  USB RX byte
- usb_rd_req  in  1  USB TX byte fetch request
- usb_ack  out  1  USB request granted (1-cycle pulse)
- usb_rvalid  out  1  usb_rdata valid
- usb_rdata  out  8  fetched byte
- ahb_wr_req  in  1  AHB byte store request
- ahb_wdata  in  8  AHB byte
- ahb_rd_req  in  1  AHB byte fetch request
- ahb_ack  out  1  AHB request granted (1-cycle pulse)
- ahb_rvalid  out  1  ahb_rdata valid
- ahb_rdata  out  8  fetched byte
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data, 1-cycle synchronous latency
- Buffer_Occupancy  out  ADDR_W+1  bytes held, 0..DEPTH
- overflow_err  out  1  write attempted while full (1-cycle pulse)
- underflow_err  out  1  read attempted while empty (1-cycle pulse)

Behaviour:
- Reset values: all outputs 0, pointers 0, stall counter 0, FSM in IDLE.
- Pointers are ADDR_W+1 bits: wr_ptr and rd_ptr, with the MSB as the wrap bit.
  - mem_addr = low ADDR_W bits of the pointer in use.
  - Buffer_Occupancy = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - full when occupancy == DEPTH; empty when occupancy == 0.
- USB eligibility:
  - D_Mode=1: only usb_wr_req is eligible; usb_rd_req is ignored.
  - D_Mode=0: only usb_rd_req is eligible.
- AHB eligibility: both requests are always eligible; if both are asserted, the write wins.
- Priority per cycle:
  1. clear/flush
  2. AHB, if the stall counter has reached MAX_STALL
  3. USB
  4. AHB
- Handshake:
  - A requester holds req and data stable until its ack pulse.
  - The ack is asserted combinationally in the grant cycle.
  - The requester may present a new request in the cycle after ack.
- Write grant, not full: mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata = the granted agent's data; wr_ptr increments at the next edge.
- Write grant, full: no memory access; ack still pulses (byte dropped); overflow_err pulses; pointers unchanged.
- Read grant, not empty: mem_en=1, mem_we=0, mem_addr=rd_ptr; rd_ptr increments at the next edge. In the next cycle, the agent's rvalid=1 and rdata=mem_rdata.
- Read grant, empty: no access; ack pulses; underflow_err pulses; the next cycle has rvalid=1 and rdata=8'h00.
- Occupancy changes by at most ±1 per cycle (single port).
- FSM states:
  - IDLE: no grant.
  - GRANT_USB.
  - GRANT_AHB.
  - RD_RESP: 1-cycle rvalid phase. A new grant may overlap RD_RESP (back-to-back reads, one per cycle).
  - CLEAR.
- clear/flush:
  - Takes effect in the cycle asserted: no grant, no ack, and pending requests stay pending.
  - wr_ptr, rd_ptr and the stall counter go to 0 at the next edge, so Buffer_Occupancy=0 one cycle later.
  - An rvalid owed from the previous cycle is still delivered.
- Stall counter:
  - Increments each cycle an eligible AHB request is not granted, saturating at MAX_STALL.
  - Resets on ahb_ack or clear/flush.
- Asynchronous reset mid-transfer: all state is dropped immediately; no rvalid is delivered afterwards.

Optional Feature:
- Macro: BUFFER_ARB_STICKY_ERR_EN.
- Defined: overflow_err and underflow_err are sticky; each stays at 1 until clear, flush or reset.
- Undefined: each error is a 1-cycle pulse, as in Behaviour.

Decomposition:
- Shared package usb_buffer_pkg:
  - DEPTH and ADDR_W constants;
  - agent enum (AGENT_NONE, AGENT_USB, AGENT_AHB);
  - arbiter state enum.
- One natural sub-module, fifo_pointer_ctrl: holds the wr/rd pointers, occupancy, full/empty and clear logic. The arbiter FSM stays in the top module.

Test Plan:
- Reset, then D_Mode=1, usb_wr_req with bytes 0x01..0x05 -> five usb_ack pulses; mem_addr 0..4 with mem_we=1; Buffer_Occupancy=5.
- Continue, then D_Mode=0, ahb_rd_req ×5 -> ahb_rvalid one cycle after each ack with ahb_rdata 0x01..0x05; occupancy returns to 0.
- Write 64 bytes, then a 65th -> occupancy=64; on the 65th, ack, no mem_en, overflow_err=1 for 1 cycle; with BUFFER_ARB_STICKY_ERR_EN, overflow_err holds until clear.
- usb_wr_req and ahb_wr_req held continuously with D_Mode=1 -> USB granted for cycles 1–4; AHB granted in cycle 5 (MAX_STALL=4); then USB again.
- Occupancy=10, then clear pulsed for 1 cycle while ahb_rd_req is held -> no ack in the clear cycle; occupancy=0 next cycle; the following AHB read gives underflow_err and ahb_rdata=0x00.
- Wrap-around: write 60, read 60, write 8 -> mem_addr sequence 60,61,62,63,0,1,2,3; occupancy=8.

Source files
------------

// File: rtl/usb_buffer_pkg.sv
// Shared types and sizes for the endpoint data buffer and its access arbiter.
package usb_buffer_pkg;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    AGENT_NONE,
    AGENT_USB,
    AGENT_AHB
  } agent_e;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_USB,
    GRANT_AHB,
    RD_RESP,
    CLEAR
  } arb_state_e;

  // One single-port SRAM access as seen on the mem_* pins.
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } mem_req_t;

endpackage

// File: rtl/fifo_pointer_ctrl.sv
// Write/read pointers with a wrap bit, occupancy and full/empty for the endpoint buffer.
module fifo_pointer_ctrl
  import usb_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              wr_inc,
  input  logic              rd_inc,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_inc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_inc) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign wr_addr   = wr_ptr[ADDR_W-1:0];
  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign empty     = (occupancy == '0);

endmodule

// File: rtl/buffer_access_arbiter.sv
// Single-port endpoint buffer arbiter between the USB and AHB agents, one byte per cycle.
// Define BUFFER_ARB_STICKY_ERR_EN to make overflow_err/underflow_err hold until clear/flush/reset.
module buffer_access_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              D_Mode,
  input  logic              clear,
  input  logic              flush,
  input  logic              usb_wr_req,
  input  logic [7:0]        usb_wdata,
  input  logic              usb_rd_req,
  output logic              usb_ack,
  output logic              usb_rvalid,
  output logic [7:0]        usb_rdata,
  input  logic              ahb_wr_req,
  input  logic [7:0]        ahb_wdata,
  input  logic              ahb_rd_req,
  output logic              ahb_ack,
  output logic              ahb_rvalid,
  output logic [7:0]        ahb_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W:0]   Buffer_Occupancy,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  arb_state_e        state, next_state;
  agent_e            grant, resp_agent_q, resp_agent_d;
  logic              resp_empty_q, resp_empty_d;
  logic              grant_wr;
  logic [7:0]        grant_data;
  logic [STALL_W-1:0] stall_cnt;
  logic              clr, usb_elig, ahb_elig, ahb_starved;
  logic              full, empty, do_wr, do_rd, ovf_c, udf_c;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  mem_req_t          mreq;

  assign clr         = clear | flush;
  assign usb_elig    = D_Mode ? usb_wr_req : usb_rd_req;
  assign ahb_elig    = ahb_wr_req | ahb_rd_req;
  assign ahb_starved = (stall_cnt == STALL_W'(MAX_STALL));

  fifo_pointer_ctrl u_ptr (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (clr),
    .wr_inc    (do_wr),
    .rd_inc    (do_rd),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .occupancy (Buffer_Occupancy),
    .full      (full),
    .empty     (empty)
  );

  // State register remembers what the previous cycle did; RD_RESP owes an rvalid now.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      resp_agent_q <= AGENT_NONE;
      resp_empty_q <= 1'b0;
    end else begin
      state        <= next_state;
      resp_agent_q <= resp_agent_d;
      resp_empty_q <= resp_empty_d;
    end
  end

  always_comb begin
    grant        = AGENT_NONE;
    grant_wr     = 1'b0;
    grant_data   = '0;
    next_state   = IDLE;
    resp_agent_d = AGENT_NONE;
    resp_empty_d = 1'b0;
    if (clr) begin
      next_state = CLEAR;
    end else if (ahb_elig && ahb_starved) begin
      grant = AGENT_AHB;
    end else if (usb_elig) begin
      grant = AGENT_USB;
    end else if (ahb_elig) begin
      grant = AGENT_AHB;
    end
    case (grant)
      AGENT_USB: begin
        grant_wr   = D_Mode;
        grant_data = usb_wdata;
      end
      AGENT_AHB: begin
        grant_wr   = ahb_wr_req;
        grant_data = ahb_wdata;
      end
      default: ;
    endcase
    if (grant != AGENT_NONE) begin
      if (!grant_wr) begin
        next_state   = RD_RESP;
        resp_agent_d = grant;
        resp_empty_d = empty;
      end else if (grant == AGENT_USB) begin
        next_state = GRANT_USB;
      end else begin
        next_state = GRANT_AHB;
      end
    end
  end

  assign do_wr = (grant != AGENT_NONE) && grant_wr && !full;
  assign do_rd = (grant != AGENT_NONE) && !grant_wr && !empty;
  assign ovf_c = (grant != AGENT_NONE) && grant_wr && full;
  assign udf_c = (grant != AGENT_NONE) && !grant_wr && empty;

  always_comb begin
    mreq = '0;
    if (do_wr) begin
      mreq.en   = 1'b1;
      mreq.we   = 1'b1;
      mreq.addr = wr_addr;
      mreq.data = grant_data;
    end else if (do_rd) begin
      mreq.en   = 1'b1;
      mreq.addr = rd_addr;
    end
  end

  assign mem_en    = mreq.en;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.data;

  assign usb_ack    = (grant == AGENT_USB);
  assign ahb_ack    = (grant == AGENT_AHB);
  assign usb_rvalid = (state == RD_RESP) && (resp_agent_q == AGENT_USB);
  assign ahb_rvalid = (state == RD_RESP) && (resp_agent_q == AGENT_AHB);
  // An underflowed read returns zero rather than whatever the SRAM holds.
  assign usb_rdata  = (usb_rvalid && !resp_empty_q) ? mem_rdata : '0;
  assign ahb_rdata  = (ahb_rvalid && !resp_empty_q) ? mem_rdata : '0;

  // Starve guard: counts cycles an eligible AHB request waits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt <= '0;
    end else if (clr || ahb_ack) begin
      stall_cnt <= '0;
    end else if (ahb_elig && !ahb_starved) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

`ifdef BUFFER_ARB_STICKY_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_c) ovf_q <= 1'b1;
      if (udf_c) udf_q <= 1'b1;
    end
  end

  assign overflow_err  = ovf_c | ovf_q;
  assign underflow_err = udf_c | udf_q;
`else
  assign overflow_err  = ovf_c;
  assign underflow_err = udf_c;
`endif

endmodule
